// File: rtl/core_store_buffer.sv
// Store buffer between the memory stage and the data bus: formats stores into
// lane-replicated words with byte selects, queues them, and drains in order.
module core_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic [29:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wsel,
    input  logic        i_bus_ack,
    input  logic [29:0] i_ld_addr,
    output logic        o_ld_hit,
    output logic        o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wsel;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wsel;
    logic        bad_funct3;
    logic        misaligned;
    logic        push;
    logic        pop;
    entry_t      head_entry;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        fmt_wdata  = i_data;
        fmt_wsel   = 4'b0000;
        bad_funct3 = 1'b0;
        misaligned = 1'b0;
        case (i_funct3)
            3'b000: begin
                fmt_wdata = {4{i_data[7:0]}};
                fmt_wsel  = 4'b0001 << i_addr[1:0];
            end
            3'b001: begin
                fmt_wdata  = {2{i_data[15:0]}};
                fmt_wsel   = 4'b0011 << {i_addr[1], 1'b0};
                misaligned = i_addr[0];
            end
            3'b010: begin
                fmt_wsel   = 4'b1111;
                misaligned = |i_addr[1:0];
            end
            default: bad_funct3 = 1'b1;
        endcase
    end

    assign o_fault    = i_st_valid & (bad_funct3 | misaligned);
    assign o_st_ready = (count_q != CNT_FULL);
    assign o_empty    = (count_q == '0);
    assign o_bus_req  = ~o_empty;

    // Faulting stores still handshake but are dropped here.
    assign push = i_st_valid & o_st_ready & ~o_fault;
    assign pop  = o_bus_req & i_bus_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (pop) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            if (push) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the entry array has no reset; valid_q and count_q gate every use
    // of it, so stale contents are never observable.
    always_ff @(posedge i_clk) begin
        if (push) begin
            entries[tail_q] <= '{addr: i_addr[31:2], wdata: fmt_wdata, wsel: fmt_wsel};
        end
    end

    assign head_entry  = entries[head_q];
    assign o_bus_addr  = o_bus_req ? head_entry.addr  : '0;
    assign o_bus_wdata = o_bus_req ? head_entry.wdata : '0;
    assign o_bus_wsel  = o_bus_req ? head_entry.wsel  : '0;

    // Word-granular alias check against committed entries only.
    always_comb begin
        o_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries[i].addr == i_ld_addr)) begin
                o_ld_hit = 1'b1;
            end
        end
    end

endmodule

// File: doc/core_store_buffer.md
# core_store_buffer

Store-side counterpart of the load-data writeback path. Accepts store requests from the memory stage, converts the rs2 value and funct3 into a lane-replicated 32-bit write word with byte selects, and queues them in a small FIFO. It drains the FIFO onto the data bus with a req/ack handshake. It also reports misaligned or illegal stores and flags loads that alias a pending store, so the core can stall them.

## Interface
- DEPTH, 2, number of buffered stores; power of two, ≥2
- i_clk  in  1  core clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_st_valid  in  1  store request from memory stage
- o_st_ready  out  1  buffer can accept a store this cycle
- i_addr  in  32  byte address (ALU result)
- i_data  in  32  store source (rs2)
- i_funct3  in  3  000 SB, 001 SH, 010 SW; others illegal
- o_fault  out  1  current request is misaligned or illegal (combinational)
- o_bus_req  out  1  write request to data bus
- o_bus_addr  out  30  word address [31:2]
- o_bus_wdata  out  32  write data, lane-replicated
- o_bus_wsel  out  4  byte selects
- i_bus_ack  in  1  bus accepted current write
- i_ld_addr  in  30  word address of a load in the memory stage
- o_ld_hit  out  1  a pending store targets i_ld_addr
- o_empty  out  1  no pending stores (fence/drain indicator)

## Operation
- **Formatting:**
  - SB: wdata = {4{i_data[7:0]}}, wsel = 4'b0001 << i_addr[1:0].
  - SH: wdata = {2{i_data[15:0]}}, wsel = 4'b0011 << {i_addr[1],1'b0}.
  - SW: wdata = i_data, wsel = 4'b1111.
- **Fault:** o_fault = i_st_valid & (illegal funct3 | (SH & i_addr[0]) | (SW & |i_addr[1:0])).
  - A faulting request completes its handshake when o_st_ready=1 but is never enqueued. The core raises the exception.
- **Push:** i_st_valid & o_st_ready & !o_fault. Writes {addr[31:2], wdata, wsel} at the tail.
- **Pop:** o_bus_req & i_bus_ack. Advances the head.
- **Ready:** o_st_ready = (count != DEPTH). It does not depend on i_bus_ack, so there is no combinational ack→ready path.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- **Bus outputs:**
  - o_bus_req = (count != 0).
  - o_bus_addr, o_bus_wdata and o_bus_wsel come from the head entry register.
  - All are forced to 0 when empty.
  - They stay stable while o_bus_req=1 and no ack.
- **Alias check:** o_ld_hit = OR over valid entries of (entry addr == i_ld_addr). Word granularity, independent of wsel. The entry being pushed in the same cycle is not included.
- o_empty = (count == 0).
- Stores retire to the bus in acceptance order. There is no merging or forwarding.

## Timing
- **Reset (synchronous):**
  - Count and pointers cleared to 0, all entries invalidated.
  - Outputs after the reset edge: o_bus_req=0, o_bus_addr=0, o_bus_wdata=0, o_bus_wsel=0, o_ld_hit=0, o_empty=1, o_st_ready=1.
  - o_fault is combinational and remains a function of its inputs during reset.
- **Reset mid-transaction:** the pending bus write is abandoned and o_bus_req is low from the cycle after the reset edge. An i_bus_ack in the reset cycle is ignored.
- **Latency:** a store pushed at edge N presents o_bus_req=1 in cycle N+1 when the buffer was empty.
- **Ack:** zero-wait ack is allowed in the same cycle req rises. The entry pops at that edge.
- **Back-to-back:** with ≥2 entries, o_bus_req stays high and the next entry is presented in the cycle after the ack.
- **Ack without req:** i_bus_ack while o_bus_req=0 is ignored.
- **Full:** o_st_ready=0 when count=DEPTH. A pop frees a slot, and ready rises in the following cycle.

## Test plan
- **Reset:** hold i_reset 2 cycles with a store pending → o_bus_req=0, o_empty=1, o_st_ready=1; a subsequent ack is ignored and count stays 0.
- **SB:** i_addr=0x1003, i_data=0xA5, funct3=000, ack immediately → o_bus_addr=0x400, o_bus_wdata=0xA5A5A5A5, o_bus_wsel=4'b1000, req for exactly 1 cycle.
- **SH/SW:** SH at 0x2002 with data 0x1234 → wdata=0x12341234, wsel=4'b1100. SW at 0x2000 with 0xDEADBEEF → wsel=4'b1111. Issued in order.
- **Faults:**
  - SH at 0x3001 → o_fault=1, not enqueued.
  - SW at 0x3002 → o_fault=1.
  - funct3=011 → o_fault=1.
  - In all three cases o_empty stays 1.
- **Full with wait states:** DEPTH=2, ack held low, push 3 stores → 3rd sees o_st_ready=0. Ack pulse → one pop, ready=1 next cycle, 3rd accepted. Bus data is stable across wait cycles.
- **Alias and contention:**
  - i_ld_addr equals the word of a pending SB at 0x1003 (0x400) → o_ld_hit=1; i_ld_addr=0x401 → 0.
  - Simultaneous push and pop at count=1 → count stays 1.
